// File: rtl/sha3_block_padder.sv
// SHA-3 absorb front end: packs 32-bit message words into rate-sized blocks,
// applies pad10*1 (0x06 ... 0x80) and hands each block to the permutation core.
module sha3_block_padder (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    out_size,
   input  logic [31:0]   in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [2:0]    in_nbytes,
   output logic [1151:0] block_out,
   output logic          block_valid,
   input  logic          block_ack,
   output logic          msg_done
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [1151:0]   blk_q, blk_d;
   logic [5:0]      wcnt_q, wcnt_d;
   logic [5:0]      rate_q, rate_d;
   logic            need06_q, need06_d;
   logic            final_q, final_d;
   logic            active_q, active_d;
   logic            done_q, done_d;

   logic [5:0]      rate_eff;
   logic [5:0]      wcnt_inc;
   logic            blk_full;
   logic [31:0]     last_word;

   function automatic logic [5:0] rate_lut(input logic [1:0] sel);
      case (sel)
         2'd0:    rate_lut = 6'd18;
         2'd1:    rate_lut = 6'd26;
         2'd2:    rate_lut = 6'd34;
         2'd3:    rate_lut = 6'd36;
         default: rate_lut = 6'd36;
      endcase
   endfunction

   // The rate is taken live from out_size only for the first word of a message.
   assign rate_eff = active_q ? rate_q : rate_lut(out_size);
   assign wcnt_inc = wcnt_q + 6'd1;
   assign blk_full = (wcnt_inc == rate_eff);

   always_comb begin
      last_word = '0;
      for (int i = 0; i < 4; i++) begin
         if (3'(i) < in_nbytes)
            last_word[31-8*i -: 8] = in_data[31-8*i -: 8];
         else if (3'(i) == in_nbytes)
            last_word[31-8*i -: 8] = 8'h06;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FILL;
         blk_q    <= '0;
         wcnt_q   <= '0;
         rate_q   <= '0;
         need06_q <= 1'b0;
         final_q  <= 1'b0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         blk_q    <= blk_d;
         wcnt_q   <= wcnt_d;
         rate_q   <= rate_d;
         need06_q <= need06_d;
         final_q  <= final_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      blk_d    = blk_q;
      wcnt_d   = wcnt_q;
      rate_d   = rate_q;
      need06_d = need06_q;
      final_d  = final_q;
      active_d = active_q;
      done_d   = 1'b0;
      case (state_q)
         S_FILL: begin
            if (in_valid) begin
               if (!active_q) begin
                  rate_d   = rate_lut(out_size);
                  active_d = 1'b1;
               end
               wcnt_d = wcnt_inc;
               if (!in_last) begin
                  blk_d = {blk_q[1119:0], in_data};
                  if (blk_full) begin
                     state_d = S_WAIT;
                     final_d = 1'b0;
                  end
               end else if (in_nbytes[2]) begin
                  // Full last word: the 0x06 byte goes into a later generated word.
                  blk_d    = {blk_q[1119:0], in_data};
                  need06_d = 1'b1;
                  final_d  = 1'b0;
                  state_d  = blk_full ? S_WAIT : S_PAD;
               end else begin
                  blk_d   = {blk_q[1119:0], last_word | (blk_full ? 32'h0000_0080 : 32'h0)};
                  final_d = blk_full;
                  state_d = blk_full ? S_WAIT : S_PAD;
               end
            end
         end
         S_PAD: begin
            blk_d    = {blk_q[1119:0], (need06_q ? 32'h0600_0000 : 32'h0)
                                       | (blk_full ? 32'h0000_0080 : 32'h0)};
            need06_d = 1'b0;
            wcnt_d   = wcnt_inc;
            final_d  = blk_full;
            if (blk_full)
               state_d = S_WAIT;
         end
         S_WAIT: begin
            if (block_ack) begin
               blk_d   = '0;
               wcnt_d  = '0;
               state_d = need06_q ? S_PAD : S_FILL;
               if (final_q) begin
                  done_d   = 1'b1;
                  final_d  = 1'b0;
                  active_d = 1'b0;
                  need06_d = 1'b0;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_comb begin
      in_ready    = (state_q == S_FILL) & ~reset;
      block_valid = (state_q == S_WAIT);
      block_out   = blk_q;
      msg_done    = done_q;
   end

endmodule
